// File: rtl/led_pattern.sv
`default_nettype none
// led_pattern: per-channel off/on/blink/heartbeat LED drive on a shared 8-phase timebase.
// Defining LED_PATTERN_DIM_EN adds a per-channel 4-bit PWM brightness input.
module led_pattern #(
  parameter int CHANNELS    = 2,
  parameter int TICK_CYCLES = 1500000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    restart_i,
  input  logic [2*CHANNELS-1:0]   mode_i,
`ifdef LED_PATTERN_DIM_EN
  input  logic [4*CHANNELS-1:0]   brightness_i,
`endif
  output logic [CHANNELS-1:0]     led_o,
  output logic                    tick_o,
  output logic [2:0]              phase_o
);

  localparam int                     c_presc_w   = $clog2(TICK_CYCLES);
  localparam logic [c_presc_w-1:0]   c_tick_last = c_presc_w'(TICK_CYCLES - 1);
  localparam logic [CHANNELS-1:0]    c_unlit     = {CHANNELS{ACTIVE_LOW}};

  logic [c_presc_w-1:0] presc_q, presc_d;
  logic [2:0]           phase_q, phase_d;
  logic                 tick_q, tick_d;
  logic [CHANNELS-1:0]  led_q, led_d;
  logic [CHANNELS-1:0]  pat, lit;
  logic                 tick_int;

  assign tick_int = (presc_q == c_tick_last);

  // Restart overrides a coincident tick: no phase advance and no tick pulse.
  always_comb begin
    presc_d = presc_q + c_presc_w'(1);
    phase_d = phase_q;
    tick_d  = tick_int;
    if (tick_int) begin
      presc_d = '0;
      phase_d = phase_q + 3'd1;
    end
    if (restart_i) begin
      presc_d = '0;
      phase_d = 3'd0;
      tick_d  = 1'b0;
    end
  end

  always_comb begin
    pat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_i[2*i +: 2])
        2'b00:   pat[i] = 1'b0;
        2'b01:   pat[i] = 1'b1;
        2'b10:   pat[i] = phase_q[2];
        default: pat[i] = ~phase_q[2] & ~phase_q[0];
      endcase
    end
  end

`ifdef LED_PATTERN_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  assign pwm_d = restart_i ? 4'd0 : pwm_q + 4'd1;

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i] = pat[i] & ((pwm_q < brightness_i[4*i +: 4]) || (brightness_i[4*i +: 4] == 4'hF));
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  assign lit = pat;
`endif

  assign led_d = lit ^ c_unlit;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc_q <= '0;
      phase_q <= 3'd0;
      tick_q  <= 1'b0;
      led_q   <= c_unlit;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

  assign led_o   = led_q;
  assign tick_o  = tick_q;
  assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern.sv
`default_nettype none
// tb_led_pattern: randomized self-checking bench; an active-high and an active-low
// instance share all stimulus and are compared against one timebase model.
module tb_led_pattern;
  localparam int CH = 2;
  localparam int TC = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          restart = 1'b0;
  logic [2*CH-1:0] mode  = '0;
  logic [CH-1:0] led0, led1;
  logic          tick0, tick1;
  logic [2:0]    ph0, ph1;
`ifdef LED_PATTERN_DIM_EN
  logic [4*CH-1:0] bright = '1;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: n counts edges since the timebase was last aligned (reset or restart).
  int          n       = 0;
  logic [CH-1:0] exp_led = '0;
  logic        exp_tick = 1'b0;

  always #5 clk = ~clk;

  led_pattern #(.CHANNELS(CH), .TICK_CYCLES(TC), .ACTIVE_LOW(1'b0)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .restart_i(restart), .mode_i(mode),
`ifdef LED_PATTERN_DIM_EN
    .brightness_i(bright),
`endif
    .led_o(led0), .tick_o(tick0), .phase_o(ph0));

  led_pattern #(.CHANNELS(CH), .TICK_CYCLES(TC), .ACTIVE_LOW(1'b1)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .restart_i(restart), .mode_i(mode),
`ifdef LED_PATTERN_DIM_EN
    .brightness_i(bright),
`endif
    .led_o(led1), .tick_o(tick1), .phase_o(ph1));

  function automatic logic [2:0] exp_ph();
    return 3'((n / TC) % 8);
  endfunction

  function automatic logic pattern(input logic [1:0] m, input int ph);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return (ph >= 4);
      default: return (ph == 0) || (ph == 2);
    endcase
  endfunction

  task automatic step();
    logic [CH-1:0] nxt;
    int ph;
    int br;
    @(posedge clk);
    if (rst_n) begin
      ph = (n / TC) % 8;
      for (int i = 0; i < CH; i++) begin
        nxt[i] = pattern(mode[2*i +: 2], ph);
`ifdef LED_PATTERN_DIM_EN
        br = int'(bright[4*i +: 4]);
        if (!(((n % 16) < br) || (br == 15))) nxt[i] = 1'b0;
`else
        br = 0;
`endif
      end
      exp_led = nxt;
      if (restart) begin
        n = 0;
        exp_tick = 1'b0;
      end else begin
        n++;
        exp_tick = ((n % TC) == 0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({led0, led1, tick0, tick1, ph0, ph1} !== {2'b00, 2'b11, 1'b0, 1'b0, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got led0=%b led1=%b tick=%b%b phase=%0d/%0d want 00 11 0 0", led0, led1, tick0, tick1, ph0, ph1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; exp_led = '0; exp_tick = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (tick0 !== (c == 4) || ph0 !== ((c == 4) ? 3'd1 : 3'd0)) begin
        failures++;
        $display("FAIL first_tick cycle=%0d got tick=%b phase=%0d want tick=%b phase=%0d", c, tick0, ph0, c == 4, (c == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_pattern(input logic [2*CH-1:0] m, input int want0, input int want1, input string name);
    int hi0 = 0, hi1 = 0;
    mode = m;
    for (int c = 0; c < 64; c++) begin
      step();
      if (c >= 32) begin
        hi0 += int'(led0[0]);
        hi1 += int'(led0[1]);
      end
      checks++;
      if ({led0, led1, tick0, tick1, ph0, ph1} !== {exp_led, ~exp_led, exp_tick, exp_tick, exp_ph(), exp_ph()}) begin
        failures++;
        $display("FAIL %s_cycle n=%0d got led=%b/%b tick=%b phase=%0d want led=%b tick=%b phase=%0d",
                 name, n, led0, led1, tick0, ph0, exp_led, exp_tick, exp_ph());
      end
    end
    checks++;
    if (hi0 != want0 || hi1 != want1) begin
      failures++;
      $display("FAIL %s_duty got lit0=%0d lit1=%0d of 32 want %0d %0d", name, hi0, hi1, want0, want1);
    end
  endtask

  task automatic test_restart();
    int guard = 0;
    mode = 4'b1110;
    while ((n % 32) != 23 && guard < 64) begin
      step();
      guard++;
    end
    checks++;
    if ((n % 32) != 23) begin
      failures++;
      $display("FAIL restart_align got n=%0d want phase 5 prescaler 3", n);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (ph0 !== 3'd0 || tick0 !== 1'b0 || led0 !== exp_led) begin
      failures++;
      $display("FAIL restart_priority got phase=%0d tick=%b led=%b want 0 0 %b", ph0, tick0, led0, exp_led);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (tick0 !== (c == 4) || ph0 !== ((c == 4) ? 3'd1 : 3'd0)) begin
        failures++;
        $display("FAIL restart_next_tick cycle=%0d got tick=%b phase=%0d want tick=%b", c, tick0, ph0, c == 4);
      end
    end
  endtask

`ifdef LED_PATTERN_DIM_EN
  task automatic test_dim();
    int hi0, hi1;
    mode = 4'b0101;
    bright = {4'd0, 4'd4};
    for (int pass = 0; pass < 2; pass++) begin
      step();
      hi0 = 0; hi1 = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        hi0 += int'(led0[0]);
        hi1 += int'(led0[1]);
        checks++;
        if ({led0, led1} !== {exp_led, ~exp_led}) begin
          failures++;
          $display("FAIL dim_cycle n=%0d got led=%b/%b want %b", n, led0, led1, exp_led);
        end
      end
      checks++;
      if (hi0 != ((pass == 0) ? 4 : 16) || hi1 != ((pass == 0) ? 0 : 16)) begin
        failures++;
        $display("FAIL dim_duty pass=%0d got lit0=%0d lit1=%0d of 16", pass, hi0, hi1);
      end
      bright = {4'd15, 4'd15};
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ((c % 8) == 0) mode = 4'($urandom);
      restart = ($urandom_range(0, 15) == 0);
`ifdef LED_PATTERN_DIM_EN
      if ((c % 16) == 0) bright = 8'($urandom);
`endif
      step();
      checks++;
      if ({led0, led1, tick0, tick1, ph0, ph1} !== {exp_led, ~exp_led, exp_tick, exp_tick, exp_ph(), exp_ph()}) begin
        failures++;
        $display("FAIL random n=%0d got led=%b/%b tick=%b phase=%0d want led=%b tick=%b phase=%0d",
                 n, led0, led1, tick0, ph0, exp_led, exp_tick, exp_ph());
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    mode = 4'b1010;
`ifdef LED_PATTERN_DIM_EN
    bright = '1;
`endif
    while (!(exp_ph() == 3'd6 && (n % TC) == 1) && guard < 64) begin
      step();
      guard++;
    end
    step();
    checks++;
    if (led1 !== 2'b00 || ph0 !== 3'd6) begin
      failures++;
      $display("FAIL pre_reset_phase6 got led1=%b phase=%0d want 00 6", led1, ph0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led0, led1, tick0, ph0, ph1} !== {2'b00, 2'b11, 1'b0, 3'd0, 3'd0}) begin
      failures++;
      $display("FAIL async_reset got led0=%b led1=%b tick=%b phase=%0d want 00 11 0 0", led0, led1, tick0, ph0);
    end
    n = 0; exp_led = '0; exp_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if ({led0, led1, tick0, ph0} !== {exp_led, ~exp_led, exp_tick, exp_ph()}) begin
        failures++;
        $display("FAIL post_reset n=%0d got led=%b tick=%b phase=%0d want %b %b %0d", n, led0, tick0, ph0, exp_led, exp_tick, exp_ph());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(4'b0010, 16, 0, "blink");
    test_pattern(4'b1111, 8, 8, "heartbeat");
    test_restart();
`ifdef LED_PATTERN_DIM_EN
    test_dim();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent LED outputs, legal range 1..16.
REQ-002 Parameter TICK_CYCLES, default 1500000: clock cycles per pattern tick (8 ticks/s at 12 MHz), legal range >=2.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every led bit at the output register.
REQ-004 clock  input  1  single system clock; all state is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 restart  input  1  synchronous pulse; realigns the pattern timebase.
REQ-007 mode  input  2*CHANNELS  per channel, bits [2i+1:2i] (00 off, 01 on, 10 blink, 11 heartbeat).
REQ-008 led  output  CHANNELS  registered LED drive.
REQ-009 tick  output  1  registered one-cycle pulse per pattern tick.
REQ-010 phase  output  3  current pattern phase, 0..7.

Function
REQ-011 Prescaler SHALL count 0..TICK_CYCLES-1 and wrap to 0; width $clog2(TICK_CYCLES).
REQ-012 Internal tick SHALL assert in the cycle the prescaler equals TICK_CYCLES-1; the tick output SHALL be that pulse, registered.
REQ-013 Phase SHALL increment by 1 on each internal tick, wrapping 7->0.
REQ-014 Restart SHALL force prescaler=0 and phase=0 on the next edge, with priority over a coincident tick: no increment and no tick pulse in that cycle.
REQ-015 Per-channel pattern bit: off=0, on=1, blink=phase[2] (lit in phases 4..7), heartbeat=1 only in phases 0 and 2.
REQ-016 led[i] SHALL be registered from the current mode and phase; a mode change SHALL be visible on led one edge later.
REQ-017 When ACTIVE_LOW=1, led[i] SHALL equal the inverse of the lit state; tick and phase SHALL be unaffected.
REQ-018 Channels SHALL share one timebase so that all blinking channels are phase-aligned.

Reset
REQ-019 Asserting reset_n low SHALL immediately clear prescaler, phase, tick, and the PWM counter, and drive every led bit unlit (0, or 1 when ACTIVE_LOW=1), including mid-pattern.
REQ-020 After deassertion, the first tick SHALL occur TICK_CYCLES edges later.

Configuration
REQ-021 Macro LED_PATTERN_DIM_EN SHALL, when defined, add input brightness (4*CHANNELS, bits [4i+3:4i]) and a free-running 4-bit PWM counter incremented every cycle, cleared by reset and restart.
REQ-022 With LED_PATTERN_DIM_EN, a channel SHALL be lit only when its pattern bit is 1 and (pwm_cnt < brightness or brightness == 15); brightness 0 SHALL keep it unlit.
REQ-023 Without LED_PATTERN_DIM_EN, the brightness port and PWM counter SHALL NOT exist and lit SHALL equal the pattern bit.

Verification (TICK_CYCLES=4, CHANNELS=2 unless stated)
REQ-024 Reset held, then released -> led=2'b00, phase=0, tick=0; first tick pulse 4 cycles after release; phase=1 after it.
REQ-025 mode=2'b10 on ch0, ch1 off -> led[0] low 16 cycles, high 16 cycles (period 32); led[1] stays 0.
REQ-026 mode=2'b11 -> led high only during phases 0 and 2 (cycles 0-3 and 8-11 of each 32-cycle frame).
REQ-027 restart in the same cycle as prescaler=3 at phase 5 -> next cycle phase=0, prescaler=0, no tick pulse; the next tick 4 cycles later.
REQ-028 LED_PATTERN_DIM_EN, mode on, brightness 4 -> led high exactly 4 of every 16 cycles; brightness 0 -> never high; brightness 15 -> always high.
REQ-029 ACTIVE_LOW=1, blink running, reset_n pulsed low mid-phase-6 -> led goes to 2'b11 without a clock edge; phase reads 0.
